uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload width; SHALL equal the serializer's width; only 8 is supported, since the serializer's done count is 3 bits.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 P_DATA  input  DATA_WIDTH  parallel byte to transmit; sampled only on accept.
REQ-005 DATA_VALID  input  1  request to send P_DATA.
REQ-006 PAR_EN  input  1  1 = append parity bit; sampled on accept.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd parity; sampled on accept.
REQ-008 ser_data  input  1  current serializer LSB.
REQ-009 ser_done  input  1  serializer's 8th-shift-cycle flag.
REQ-010 load  output  1  serializer parallel-load strobe.
REQ-011 ser_en  output  1  serializer shift enable.
REQ-012 TX_OUT  output  1  UART line; idle high.
REQ-013 Busy  output  1  frame in progress.

Function
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY and STOP; one bit period equals one CLK cycle.
REQ-015 Accept SHALL occur when DATA_VALID=1 and state is IDLE or STOP.
REQ-016 On accept:
- load=1 combinationally in that cycle.
- P_DATA parity, PAR_EN and PAR_TYP latched at the same edge.
- Next state START.
REQ-017 IDLE SHALL drive TX_OUT=1, Busy=0, load=0 unless accepting, and ser_en=0.
REQ-018 START SHALL drive TX_OUT=0, Busy=1 and ser_en=0 for exactly one cycle, then go to DATA.
REQ-019 DATA SHALL drive ser_en=1, TX_OUT=ser_data and Busy=1.
- First DATA cycle SHALL carry P_DATA[0] (LSB first).
REQ-020 DATA exit: when ser_done=1 in a DATA cycle, the next state SHALL be PARITY if latched PAR_EN=1, else STOP.
- DATA therefore lasts exactly 8 cycles.
REQ-021 PARITY SHALL last one cycle with TX_OUT = latched parity bit, Busy=1 and ser_en=0, then go to STOP.
REQ-022 Parity bit SHALL be XOR-reduce(P_DATA) for even and its inverse for odd, computed from the value captured at accept.
REQ-023 STOP SHALL last one cycle with TX_OUT=1 and Busy=1.
- Next state START if accepting (back-to-back frame, no idle gap).
- Otherwise next state IDLE.
REQ-024 DATA_VALID in START, DATA or PARITY SHALL be ignored: no load, no latch, no queuing.
REQ-025 Outputs SHALL be decoded only from the state register and latched values, except load (DATA_VALID-qualified) and TX_OUT in DATA (ser_data).
REQ-026 Frame length SHALL be 10 cycles without parity and 11 cycles with parity.
REQ-027 load and ser_en SHALL never be asserted in the same cycle.
REQ-028 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-029 With RST=1 at a rising edge, the next state SHALL be IDLE and the latched parity/PAR_EN/PAR_TYP SHALL clear to 0.
- Outputs then read TX_OUT=1, Busy=0, load=0, ser_en=0.
REQ-030 Reset mid-frame SHALL abort the frame with no stop or parity bit emitted.
- The serializer's count self-clears because ser_en drops.
REQ-031 DATA_VALID held high during reset SHALL be accepted on the first cycle after RST deasserts.

Structure
REQ-032 The shared UART package SHALL hold the FSM state encodings, the PAR_TYP constants (EVEN=0, ODD=1) and the line levels (START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1).
REQ-033 The parity computation SHALL be one sub-module, parity_calc (inputs: data, PAR_TYP; output: parity bit).
- It is reusable by the RX parity checker.
REQ-034 The output mux SHALL be inline in uart_tx_ctrl, not a separate module.

Verification
REQ-035 The bench SHALL pair the block with the existing TX serializer at DATA_WIDTH=8.
REQ-036 Scenario 1: P_DATA=0xA5, PAR_EN=0, one-cycle DATA_VALID -> TX_OUT = 0,1,0,1,0,0,1,0,1,1, then high.
- Busy high for 10 cycles.
REQ-037 Scenario 2: 0xA5 with PAR_EN=1:
- PAR_TYP=0 -> parity bit 0 before the stop bit.
- PAR_TYP=1 -> parity bit 1.
- 11 cycles each.
REQ-038 Scenario 3: DATA_VALID held high with 0x01 then 0xFF -> the second START immediately follows the first STOP.
- Busy never drops.
- Second frame = 0, eight 1s, 1.
REQ-039 Scenario 4: DATA_VALID pulsed with P_DATA=0x00 during DATA of frame 0x3C -> frame 0x3C transmitted intact, no load pulse.
REQ-040 Scenario 5: RST asserted in the 4th DATA cycle -> the next cycle shows TX_OUT=1, Busy=0, ser_en=0.
- A following 0x55 frame is correct.
REQ-041 Scenario 6: assertion checks throughout -> load and ser_en are mutually exclusive, and ser_en is high exactly 8 consecutive cycles per frame.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ctrl_pkg
//  Purpose  : Shared UART definitions: TX FSM state encodings, parity-type
//             constants and serial line levels.
//  Revision : 1.0  initial release
// ============================================================================
package uart_tx_ctrl_pkg;

  // TX frame sequencer states; values 5..7 are unreachable
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // PAR_TYP encodings
  localparam logic c_PAR_EVEN = 1'b0;
  localparam logic c_PAR_ODD  = 1'b1;

  // Serial line levels
  localparam logic c_START_BIT  = 1'b0;
  localparam logic c_STOP_BIT   = 1'b1;
  localparam logic c_IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_ctrl_parity_calc.sv
`default_nettype none
// ============================================================================
//  Module   : parity_calc
//  Purpose  : UART parity generator. Even parity is the XOR-reduce of the
//             data word, odd parity its inverse. Shared with the RX checker.
//  Revision : 1.0  initial release
// ============================================================================
module parity_calc
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  PAR_TYP,
  output logic                  par_bit
);

  logic w_xor;

  // Even parity is the plain XOR-reduce; odd parity flips it
  always_comb begin
    w_xor   = ^data;
    par_bit = (PAR_TYP == c_PAR_ODD) ? ~w_xor : w_xor;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ctrl
//  Purpose  : UART transmit controller. Sequences START / DATA / PARITY /
//             STOP (one bit per clock), drives the external serializer's
//             load and shift-enable strobes and muxes the TX line.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  // Must match the serializer width; only 8 works because the serializer's
  // done flag comes from a 3-bit shift counter.
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  load,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e r_state;
  tx_state_e w_next_state;
  logic      r_par_bit;   // parity bit of the accepted byte, PAR_TYP already applied
  logic      r_par_en;    // PAR_EN captured at accept
  logic      w_par_bit;
  logic      w_accept;

  // Parity of the live byte; only meaningful in the accept cycle
  parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data    (P_DATA),
    .PAR_TYP (PAR_TYP),
    .par_bit (w_par_bit)
  );

  // A new frame may start from IDLE or directly out of STOP; never while
  // reset is asserted so the serializer is not loaded during reset.
  assign w_accept = DATA_VALID && !RST &&
                    ((r_state == ST_IDLE) || (r_state == ST_STOP));

  // State register and per-frame settings captured on accept
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_par_bit <= w_par_bit;
        r_par_en  <= PAR_EN;
      end
    end
  end

  // Next-state decode and output mux
  always_comb begin
    w_next_state = ST_IDLE;
    load         = w_accept;
    ser_en       = 1'b0;
    TX_OUT       = c_IDLE_LEVEL;
    Busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_state = w_accept ? ST_START : ST_IDLE;
      end
      ST_START: begin
        TX_OUT       = c_START_BIT;
        Busy         = 1'b1;
        w_next_state = ST_DATA;
      end
      ST_DATA: begin
        TX_OUT       = ser_data;
        Busy         = 1'b1;
        ser_en       = 1'b1;
        if (ser_done) begin
          w_next_state = r_par_en ? ST_PARITY : ST_STOP;
        end else begin
          w_next_state = ST_DATA;
        end
      end
      ST_PARITY: begin
        TX_OUT       = r_par_bit;
        Busy         = 1'b1;
        w_next_state = ST_STOP;
      end
      ST_STOP: begin
        TX_OUT       = c_STOP_BIT;
        Busy         = 1'b1;
        w_next_state = w_accept ? ST_START : ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_ctrl
//  Purpose  : Bench for uart_tx_ctrl paired with an 8-bit TX serializer.
//             A frame-level reference model predicts every output each cycle;
//             directed scenarios pin exact line waveforms.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_data;
  logic       ser_done;
  logic       load;
  logic       ser_en;
  logic       TX_OUT;
  logic       Busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .load       (load),
    .ser_en     (ser_en),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  // 8-bit TX serializer: LSB-first shift register with a shift counter that
  // clears whenever ser_en is low; done flags the 8th shift cycle.
  logic [7:0] ser_sr;
  logic [2:0] ser_cnt;
  always @(posedge CLK) begin
    if (RST) begin
      ser_cnt <= 3'd0;
    end else if (load) begin
      ser_sr  <= P_DATA;
      ser_cnt <= 3'd0;
    end else if (ser_en) begin
      ser_sr  <= ser_sr >> 1;
      ser_cnt <= ser_cnt + 3'd1;
    end else begin
      ser_cnt <= 3'd0;
    end
  end
  assign ser_data = ser_sr[0];
  assign ser_done = (ser_cnt == 3'd7);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line bits of a whole frame, bit 0 sent first: start, 8 data LSB first,
  // optional parity, stop (unused upper bits are 1 = idle/stop level).
  function automatic logic [10:0] frame_tx(input logic [7:0] d, input logic pe, input logic pt);
    logic [10:0] v;
    v      = '1;
    v[0]   = 1'b0;
    v[8:1] = d;
    if (pe) v[9] = (^d) ^ pt;
    return v;
  endfunction

  // Reference model: queue of remaining bit slots of the frame on the line
  typedef struct packed { logic tx; logic sen; } slot_t;
  slot_t mq[$];

  always @(posedge CLK) begin : p_model
    logic        acc;
    logic [10:0] v;
    int          n;
    acc = !RST && DATA_VALID && (mq.size() <= 1);
    if (RST) begin
      mq.delete();
    end else begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        v = frame_tx(P_DATA, PAR_EN, PAR_TYP);
        n = PAR_EN ? 11 : 10;
        for (int i = 0; i < n; i++) mq.push_back('{tx: v[i], sen: (i >= 1 && i <= 8)});
      end
    end
  end

  // Per-cycle output trace for the directed scenarios
  typedef struct packed { logic tx; logic busy; logic sen; logic ld; } tr_t;
  tr_t trace[$];
  int  run_len = 0;
  bit  run_aborted = 1'b0;

  // Compare DUT outputs against the model every cycle
  always @(negedge CLK) begin : p_cmp
    logic e_tx, e_busy, e_sen, e_ld;
    if (mq.size() > 0) begin
      e_tx = mq[0].tx; e_sen = mq[0].sen; e_busy = 1'b1;
    end else begin
      e_tx = 1'b1; e_sen = 1'b0; e_busy = 1'b0;
    end
    e_ld = !RST && DATA_VALID && (mq.size() <= 1);
    check("tx_out", 32'(TX_OUT), 32'(e_tx));
    check("busy",   32'(Busy),   32'(e_busy));
    check("ser_en", 32'(ser_en), 32'(e_sen));
    check("load",   32'(load),   32'(e_ld));
    check("load_ser_en_excl", 32'(load && ser_en), 32'd0);
    if (ser_en) begin
      run_len++;
      if (RST) run_aborted = 1'b1;
    end else begin
      if (run_len > 0 && !run_aborted) check("ser_en_run_len", 32'(run_len), 32'd8);
      run_len     = 0;
      run_aborted = 1'b0;
    end
    trace.push_back('{tx: TX_OUT, busy: Busy, sen: ser_en, ld: load});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One-cycle request; b returns the trace index of the START cycle
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, output int b);
    DATA_VALID = 1'b1;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    b          = trace.size() + 1;
    tick(1);
    DATA_VALID = 1'b0;
  endtask

  task automatic check_frame(input string name, input int b, input logic [9:0] exp);
    logic [9:0] e;
    e = exp;
    for (int i = 0; i < 10; i++) check(name, 32'(trace[b+i].tx), 32'(e[i]));
  endtask

  initial begin : p_stim
    int          b;
    int          nb;
    logic [10:0] fv;

    RST = 1'b1; DATA_VALID = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    tick(3);
    check("reset_tx",     32'(TX_OUT), 32'd1);
    check("reset_busy",   32'(Busy),   32'd0);
    check("reset_ser_en", 32'(ser_en), 32'd0);
    check("reset_load",   32'(load),   32'd0);

    // Pin the model's frame builder with hand-derived values
    fv = frame_tx(8'hA5, 1'b0, 1'b0);
    check("model_a5_frame", 32'(fv[9:0]), 32'h34A);
    fv = frame_tx(8'hA5, 1'b1, 1'b0);
    check("model_a5_even_par", 32'(fv[9]), 32'd0);
    fv = frame_tx(8'hA5, 1'b1, 1'b1);
    check("model_a5_odd_par", 32'(fv[10:9]), 32'd3);

    RST = 1'b0;
    tick(2);

    // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1 then idle; Busy for 10 cycles
    send(8'hA5, 1'b0, 1'b0, b);
    tick(12);
    check_frame("s1_a5_line", b, 10'b1101001010);
    nb = 0;
    for (int i = 0; i < 12; i++) nb += int'(trace[b+i].busy);
    check("s1_busy_len", 32'(nb), 32'd10);
    check("s1_idle_after", 32'(trace[b+10].tx), 32'd1);
    tick(2);

    // 0xA5 with even then odd parity: 11-cycle frames
    for (int pt = 0; pt < 2; pt++) begin
      send(8'hA5, 1'b1, 1'(pt), b);
      tick(12);
      check("s2_parity_bit", 32'(trace[b+9].tx), 32'(pt));
      check("s2_stop_bit", 32'(trace[b+10].tx), 32'd1);
      nb = 0;
      for (int i = 0; i < 12; i++) nb += int'(trace[b+i].busy);
      check("s2_busy_len", 32'(nb), 32'd11);
      tick(2);
    end

    // Back-to-back: 0x01 then 0xFF with DATA_VALID held high
    DATA_VALID = 1'b1; P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    b = trace.size() + 1;
    tick(1);
    P_DATA = 8'hFF;
    tick(10);
    DATA_VALID = 1'b0;
    tick(10);
    nb = 0;
    for (int i = 0; i < 20; i++) nb += int'(trace[b+i].busy);
    check("s3_busy_never_drops", 32'(nb), 32'd20);
    check_frame("s3_first_frame", b, 10'b1000000010);
    check_frame("s3_second_frame", b + 10, 10'b1111111110);
    tick(2);

    // Request during DATA of frame 0x3C must be ignored
    send(8'h3C, 1'b0, 1'b0, b);
    tick(3);
    DATA_VALID = 1'b1; P_DATA = 8'h00;
    tick(1);
    DATA_VALID = 1'b0;
    tick(8);
    check_frame("s4_3c_intact", b, 10'b1001111000);
    check("s4_no_load", 32'(trace[b+3].ld), 32'd0);
    check("s4_no_queued_frame", 32'(trace[b+10].busy), 32'd0);
    tick(2);

    // Reset in the 4th DATA cycle aborts the frame; then 0x55 is clean
    send(8'h99, 1'b1, 1'b0, b);
    tick(4);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    tick(1);
    check("s5_sen_before_rst", 32'(trace[b+4].sen), 32'd1);
    check("s5_tx_after_rst",   32'(trace[b+5].tx),  32'd1);
    check("s5_busy_after_rst", 32'(trace[b+5].busy), 32'd0);
    check("s5_sen_after_rst",  32'(trace[b+5].sen), 32'd0);
    tick(1);
    send(8'h55, 1'b0, 1'b0, b);
    tick(12);
    check_frame("s5_55_frame", b, 10'b1010101010);
    tick(2);

    // DATA_VALID held through reset is accepted right after release
    RST = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    tick(3);
    RST = 1'b0;
    #1;
    check("s7_load_after_rst", 32'(load), 32'd1);
    b = trace.size() + 1;
    tick(1);
    DATA_VALID = 1'b0;
    tick(12);
    check("s7_start", 32'(trace[b].tx), 32'd0);
    check("s7_odd_parity", 32'(trace[b+9].tx), 32'd1);
    check("s7_end_idle", 32'(trace[b+11].busy), 32'd0);
    tick(2);

    // Randomized traffic including occasional resets
    for (int i = 0; i < 800; i++) begin
      RST        = ($urandom_range(0, 99) == 0);
      DATA_VALID = ($urandom_range(0, 3) == 0);
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom_range(0, 1));
      PAR_TYP    = 1'($urandom_range(0, 1));
      tick(1);
    end
    RST = 1'b0; DATA_VALID = 1'b0;
    tick(15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
